byte_serializer: RTL and testbench
==================================

BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter IDLE_BIT, default 1'b0, SHALL set the value driven on out_bit when no byte is being shifted.
REQ-003 Parameter MSB_FIRST, default 1, SHALL select bit order: 1 = bit 7 first, 0 = bit 0 first.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_data  input  8  byte to serialize; sampled only on an accept.
REQ-007 in_valid  input  1  upstream offers in_data this cycle.
REQ-008 in_ready  output  1  block can accept a byte this cycle.
REQ-009 out_bit  output  1  serial bit, one per clock; feeds the downstream pattern detector's data_in.
REQ-010 out_valid  output  1  out_bit carries payload this cycle.
REQ-011 out_last  output  1  out_bit is the final bit of the current byte.
REQ-012 busy  output  1  high when the FIFO is non-empty or a byte is shifting.

Function
REQ-013 An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_valid with in_ready=0 SHALL have no effect.
REQ-014 The block SHALL hold a 2-entry byte FIFO plus an 8-bit shift register and a 3-bit bit counter.
REQ-015 in_ready SHALL equal (FIFO count < 2), derived from registered state only; a pop in the same cycle SHALL NOT raise in_ready.
REQ-016 The FSM SHALL have two states: IDLE and SHIFT.
REQ-017 IDLE with FIFO count > 0 at a clock edge: pop head into the shift register, clear the counter, go to SHIFT.
REQ-018 IDLE with FIFO empty: stay IDLE. A byte pushed on an edge SHALL be popped no earlier than the next edge (no bypass).
REQ-019 SHIFT: out_valid=1, and out_bit = shift-register bit 7 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0).
REQ-020 SHIFT with counter < 7: shift by one toward the output end and increment the counter on each edge.
REQ-021 out_last SHALL be 1 exactly when state is SHIFT and the counter is 7.
REQ-022 SHIFT with counter = 7 and FIFO count > 0: reload from the FIFO head on that edge and stay in SHIFT, with no gap cycle between bytes.
REQ-023 SHIFT with counter = 7 and FIFO empty: go to IDLE.
REQ-024 IDLE: out_valid=0, out_last=0, out_bit=IDLE_BIT.
REQ-025 Latency: a byte accepted into an empty, IDLE block on edge E SHALL present its first bit in the cycle following edge E+1.
REQ-026 Simultaneous push and pop on one edge SHALL leave the FIFO count unchanged, with correct FIFO order.
REQ-027 The FIFO pointers SHALL wrap modulo 2, and count SHALL never exceed 2 or go below 0.
REQ-028 Sustained throughput SHALL be 1 byte per 8 clocks; upstream stalls only via in_ready.

Reset
REQ-029 While rst=1 at an edge: state=IDLE, FIFO count=0, pointers=0, counter=0, shift register=0.
REQ-030 During and after reset: out_valid=0, out_last=0, out_bit=IDLE_BIT, busy=0, in_ready=1 from the first cycle after reset.
REQ-031 While rst=1, in_ready SHALL be 0.
REQ-032 Reset asserted mid-byte SHALL abort the byte and discard FIFO contents; no partial bits SHALL follow reset release.

Verification
REQ-033 Single byte: push 0xB0 into an idle block, MSB_FIRST=1 -> out_bit 1,0,1,1,0,0,0,0 on 8 consecutive out_valid cycles; out_last on the 8th; then IDLE and busy=0.
REQ-034 Back-to-back: push 0xB0, 0x5A, 0xFF with in_valid held high -> 24 contiguous out_valid cycles with no gap.
REQ-035 Backpressure: in_ready=0 after 2 queued bytes plus 1 shifting, and rises the cycle after the first reload.
REQ-036 Stalled byte: a byte offered while in_ready=0 is not accepted and never appears on out_bit.
REQ-037 LSB-first: MSB_FIRST=0, push 0x0D -> out_bit 1,0,1,1,0,0,0,0.
REQ-038 Mid-reset: assert rst at bit 3 of 0xB0 with a second byte queued -> next cycle out_valid=0 and busy=0; nothing is emitted after release until a new push.

Source files
------------

// File: rtl/byte_serializer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | byte_serializer: 2-entry byte FIFO feeding an 8-bit shift register      |
// | that emits one bit per clock, with configurable bit order.              |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module byte_serializer #(
   parameter logic IDLE_BIT  = 1'b0,
   parameter int   MSB_FIRST = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_bit,
   output logic       out_valid,
   output logic       out_last,
   output logic       busy
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0] r_state;
   logic [0:0] w_next_state;
   logic [7:0] r_fifo [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic [7:0] r_shift;
   logic [2:0] r_bit_cnt;

   logic       w_push;
   logic       w_pop;
   logic       w_fifo_nonempty;
   logic       w_byte_done;
   logic [7:0] w_shift_next;
   logic       w_tap;

   // Ready depends only on registered occupancy, so a same-cycle pop never raises it.
   assign in_ready        = ~rst & (r_count != 2'd2);
   assign w_push          = in_valid & in_ready;
   assign w_fifo_nonempty = (r_count != 2'd0);
   assign w_byte_done     = (r_state == S_SHIFT) && (r_bit_cnt == 3'd7);
   assign w_pop           = w_fifo_nonempty && ((r_state == S_IDLE) || w_byte_done);
   assign busy            = w_fifo_nonempty || (r_state == S_SHIFT);

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign w_shift_next = {r_shift[6:0], 1'b0};
         assign w_tap        = r_shift[7];
      end else begin : g_lsb_first
         assign w_shift_next = {1'b0, r_shift[7:1]};
         assign w_tap        = r_shift[0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_fifo_nonempty) w_next_state = S_SHIFT;
         S_SHIFT: if (w_byte_done && !w_fifo_nonempty) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_bit   = IDLE_BIT;
      if (r_state == S_SHIFT) begin
         out_valid = 1'b1;
         out_last  = (r_bit_cnt == 3'd7);
         out_bit   = w_tap;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
         r_shift   <= 8'd0;
         r_bit_cnt <= 3'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= in_data;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         // Reload on the last bit keeps consecutive bytes gap-free.
         if (w_pop) begin
            r_shift   <= r_fifo[r_rd_ptr];
            r_bit_cnt <= 3'd0;
         end else if ((r_state == S_SHIFT) && (r_bit_cnt != 3'd7)) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_byte_serializer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_byte_serializer: randomized and directed bench with a queue model,   |
// | driving an MSB-first/IDLE 0 and an LSB-first/IDLE 1 instance together.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_byte_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'd0;
   logic       in_valid = 1'b0;

   logic m_ready, m_bit, m_valid, m_last, m_busy;
   logic l_ready, l_bit, l_valid, l_last, l_busy;

   always #5 clk = ~clk;

   byte_serializer #(.IDLE_BIT(1'b0), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(m_ready), .out_bit(m_bit), .out_valid(m_valid),
      .out_last(m_last), .busy(m_busy));

   byte_serializer #(.IDLE_BIT(1'b1), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(l_ready), .out_bit(l_bit), .out_valid(l_valid),
      .out_last(l_last), .busy(l_busy));

   int checks   = 0;
   int failures = 0;

   // Model: bytes waiting, plus the byte currently on the wire and its bit index.
   logic [7:0] q[$];
   bit         md_active = 0;
   int         md_idx    = 0;
   logic [7:0] md_cur    = 8'd0;
   bit         md_acc    = 0;

   logic [31:0] msb_cap, lsb_cap;
   int          msb_n, lsb_n, run, max_run;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic clear_cap();
      msb_cap = 0; lsb_cap = 0; msb_n = 0; lsb_n = 0; run = 0; max_run = 0;
   endtask

   task automatic model_edge(input bit v, input logic [7:0] d, input bit r);
      md_acc = v && !r && (q.size() < 2);
      if (r) begin
         q.delete();
         md_active = 0;
         md_idx    = 0;
         md_cur    = 8'd0;
      end else begin
         if (!md_active || md_idx == 7) begin
            if (q.size() > 0) begin
               md_cur    = q.pop_front();
               md_active = 1;
               md_idx    = 0;
            end else begin
               md_active = 0;
            end
         end else begin
            md_idx++;
         end
         if (md_acc) q.push_back(d);
      end
   endtask

   task automatic check_outputs();
      logic e_valid, e_last, e_busy, e_ready, e_mbit, e_lbit;
      e_valid = md_active;
      e_last  = md_active && (md_idx == 7);
      e_busy  = md_active || (q.size() > 0);
      e_ready = !rst && (q.size() < 2);
      e_mbit  = md_active ? md_cur[7 - md_idx] : 1'b0;
      e_lbit  = md_active ? md_cur[md_idx]     : 1'b1;
      chk("msb_valid", {31'd0, m_valid}, {31'd0, e_valid});
      chk("msb_last",  {31'd0, m_last},  {31'd0, e_last});
      chk("msb_busy",  {31'd0, m_busy},  {31'd0, e_busy});
      chk("msb_ready", {31'd0, m_ready}, {31'd0, e_ready});
      chk("msb_bit",   {31'd0, m_bit},   {31'd0, e_mbit});
      chk("lsb_valid", {31'd0, l_valid}, {31'd0, e_valid});
      chk("lsb_last",  {31'd0, l_last},  {31'd0, e_last});
      chk("lsb_bit",   {31'd0, l_bit},   {31'd0, e_lbit});
      if (m_valid) begin msb_cap = {msb_cap[30:0], m_bit}; msb_n++; end
      if (l_valid) begin lsb_cap = {lsb_cap[30:0], l_bit}; lsb_n++; end
      run     = m_valid ? run + 1 : 0;
      max_run = (run > max_run) ? run : max_run;
   endtask

   // Inputs change on the falling edge; outputs are checked on the next falling edge.
   task automatic step(input bit v, input logic [7:0] d, input bit r);
      in_valid = v;
      in_data  = d;
      rst      = r;
      @(posedge clk);
      model_edge(v, d, r);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      logic [7:0] b2b [3];
      int         accepted;
      bit         ready_at [32];
      b2b[0] = 8'hB0; b2b[1] = 8'h5A; b2b[2] = 8'hFF;

      @(negedge clk);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
      chk("reset_ready_low", {31'd0, m_ready}, 32'd0);
      step(0, 8'h00, 0);
      chk("post_reset_ready", {31'd0, m_ready}, 32'd1);
      chk("post_reset_idle_bit_lsb", {31'd0, l_bit}, 32'd1);

      // Single byte: first bit in the cycle after E+1, then back to idle.
      clear_cap();
      step(1, 8'hB0, 0);
      chk("latency_e", {31'd0, m_valid}, 32'd0);
      step(0, 8'h00, 0);
      chk("latency_e1", {31'd0, m_valid}, 32'd1);
      for (int i = 0; i < 10; i++) step(0, 8'h00, 0);
      chk("single_bits", msb_cap, 32'h0000_00B0);
      chk("single_count", msb_n, 32'd8);
      chk("single_busy_end", {31'd0, m_busy}, 32'd0);

      // LSB-first instance on 0x0D emits 1,0,1,1,0,0,0,0.
      clear_cap();
      step(1, 8'h0D, 0);
      for (int i = 0; i < 11; i++) step(0, 8'h00, 0);
      chk("lsb_bits", lsb_cap, 32'h0000_00B0);

      // Back-to-back with a stalled byte offered while not ready.
      clear_cap();
      accepted = 0;
      for (int s = 0; s < 30; s++) begin
         if (accepted < 3)          step(1, b2b[accepted], 0);
         else if (q.size() == 2)    step(1, 8'h33, 0);
         else                       step(0, 8'h00, 0);
         if (md_acc) accepted++;
         ready_at[s] = m_ready;
      end
      chk("b2b_run", max_run, 32'd24);
      chk("b2b_count", msb_n, 32'd24);
      chk("b2b_bits", msb_cap, 32'h00B0_5AFF);
      chk("bp_ready_full", {31'd0, ready_at[3]}, 32'd0);
      chk("bp_ready_pre_reload", {31'd0, ready_at[8]}, 32'd0);
      chk("bp_ready_after_reload", {31'd0, ready_at[9]}, 32'd1);

      // Reset at bit 3 of 0xB0 with 0x5A queued.
      step(1, 8'hB0, 0);
      step(1, 8'h5A, 0);
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);
      step(0, 8'h00, 1);
      chk("midrst_valid", {31'd0, m_valid}, 32'd0);
      chk("midrst_busy", {31'd0, m_busy}, 32'd0);
      clear_cap();
      for (int i = 0; i < 20; i++) step(0, 8'h00, 0);
      chk("midrst_silent", msb_n, 32'd0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 199) == 0);
      end
      for (int i = 0; i < 20; i++) step(0, 8'h00, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
